// File: rtl/control_part_scan_if.sv
// Bundles the control/config, fmap-memory and PE-side signals of the 3x3 window scanner.
// The master modport is the scanner itself; the slave modport is the memory/PE/host environment.
interface control_part_scan_if #(
    parameter int DW   = 8,
    parameter int AW_W = 7,
    parameter int AW_H = 3,
    parameter int BW   = 128
) ();
    logic                start;
    logic [AW_W:0]       cfg_w;
    logic [AW_H:0]       cfg_h;
    logic                cfg_pad;
    logic                cfg_stride2;
    logic                cfg_bias_en;
    logic                pause;
    logic [AW_W*9-1:0]   readi_w;
    logic [AW_H*9-1:0]   readi_h;
    logic [8:0]          rd_en;
    logic [DW*9-1:0]     fmaps;
    logic [BW-1:0]       biases;
    logic [DW*9-1:0]     fmap;
    logic [BW-1:0]       biasp;
    logic                en_pe_out;
    logic                busy;
    logic                done;

    modport master (
        input  start, cfg_w, cfg_h, cfg_pad, cfg_stride2, cfg_bias_en, pause, fmaps, biases,
        output readi_w, readi_h, rd_en, fmap, biasp, en_pe_out, busy, done
    );

    modport slave (
        output start, cfg_w, cfg_h, cfg_pad, cfg_stride2, cfg_bias_en, pause, fmaps, biases,
        input  readi_w, readi_h, rd_en, fmap, biasp, en_pe_out, busy, done
    );
endinterface

// File: rtl/control_part_scan.sv
// 3x3 window scanner: walks window centres over the fmap, issues per-tap reads with zero padding,
// and re-aligns the returned tap data (masked) and bias with a PE valid strobe after RD_LAT cycles.
module control_part_scan #(
    parameter int DW     = 8,
    parameter int AW_W   = 7,
    parameter int AW_H   = 3,
    parameter int BW     = 128,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_part_scan_if.master  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [AW_W:0] X_ZERO = {(AW_W+1){1'b0}};
    localparam logic [AW_W:0] X_ONE  = {{AW_W{1'b0}}, 1'b1};
    localparam logic [AW_H:0] Y_ZERO = {(AW_H+1){1'b0}};
    localparam logic [AW_H:0] Y_ONE  = {{AW_H{1'b0}}, 1'b1};
    localparam logic [2:0]    DRAIN_LAST = 3'(RD_LAT - 1);

    logic [1:0]      state_r;
    logic [AW_W:0]   w_r;
    logic [AW_H:0]   h_r;
    logic            pad_r;
    logic            s2_r;
    logic            bias_en_r;
    logic [AW_W:0]   x_r;
    logic [AW_H:0]   y_r;
    logic [2:0]      drain_r;
    logic [8:0]      mask_pipe_r [RD_LAT];
    logic [RD_LAT-1:0] valid_pipe_r;

    logic [AW_W+1:0] x_sum_s;
    logic [AW_W+1:0] x_hi_s;
    logic [AW_H+1:0] y_sum_s;
    logic [AW_H+1:0] y_hi_s;
    logic            last_x_s;
    logic            last_y_s;
    logic            issue_s;
    logic [8:0]      rd_en_s;
    logic [AW_W*9-1:0] readi_w_s;
    logic [AW_H*9-1:0] readi_h_s;
    logic [DW*9-1:0] fmap_s;
    logic [BW-1:0]   biasp_s;
    logic [8:0]      mask_d_s;
    logic            en_d_s;

    // Next-centre arithmetic and end-of-row / end-of-map detection (one extra bit avoids wrap)
    always_comb begin
        x_sum_s  = {1'b0, x_r} + {{AW_W{1'b0}}, s2_r, ~s2_r};
        y_sum_s  = {1'b0, y_r} + {{AW_H{1'b0}}, s2_r, ~s2_r};
        if (pad_r) begin
            x_hi_s = {1'b0, w_r} - {{(AW_W+1){1'b0}}, 1'b1};
            y_hi_s = {1'b0, h_r} - {{(AW_H+1){1'b0}}, 1'b1};
        end else begin
            x_hi_s = {1'b0, w_r} - {{AW_W{1'b0}}, 2'd2};
            y_hi_s = {1'b0, h_r} - {{AW_H{1'b0}}, 2'd2};
        end
        last_x_s = (x_sum_s > x_hi_s);
        last_y_s = (y_sum_s > y_hi_s);
        issue_s  = (state_r == ST_SCAN) && !bus.pause;
    end

    // Per-tap address and read enable; tap coordinates are kept offset by +1 so they stay unsigned
    always_comb begin : tap_gen
        logic [1:0]      cc;
        logic [1:0]      rr;
        logic [AW_W+1:0] tx1;
        logic [AW_H+1:0] ty1;
        rd_en_s   = 9'd0;
        readi_w_s = {(AW_W*9){1'b0}};
        readi_h_s = {(AW_H*9){1'b0}};
        cc  = 2'd0;
        rr  = 2'd0;
        tx1 = {(AW_W+2){1'b0}};
        ty1 = {(AW_H+2){1'b0}};
        if (state_r == ST_SCAN) begin
            for (int k = 0; k < 9; k++) begin
                cc  = 2'(k % 3);
                rr  = 2'(k / 3);
                tx1 = {1'b0, x_r} + {{AW_W{1'b0}}, cc};
                ty1 = {1'b0, y_r} + {{AW_H{1'b0}}, rr};
                if ((tx1 != {(AW_W+2){1'b0}}) && (tx1 <= {1'b0, w_r}) &&
                    (ty1 != {(AW_H+2){1'b0}}) && (ty1 <= {1'b0, h_r})) begin
                    readi_w_s[AW_W*9-1-AW_W*k -: AW_W] = x_r[AW_W-1:0] + {{(AW_W-2){1'b0}}, cc}
                                                       - {{(AW_W-1){1'b0}}, 1'b1};
                    readi_h_s[AW_H*9-1-AW_H*k -: AW_H] = y_r[AW_H-1:0] + {{(AW_H-2){1'b0}}, rr}
                                                       - {{(AW_H-1){1'b0}}, 1'b1};
                    if (!bus.pause) begin
                        rd_en_s[8-k] = 1'b1;
                    end else begin
                        rd_en_s[8-k] = 1'b0;
                    end
                end else begin
                    rd_en_s[8-k] = 1'b0;
                end
            end
        end else begin
            rd_en_s = 9'd0;
        end
    end

    // Scan FSM, config latch and centre counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            w_r       <= X_ZERO;
            h_r       <= Y_ZERO;
            pad_r     <= 1'b0;
            s2_r      <= 1'b0;
            bias_en_r <= 1'b0;
            x_r       <= X_ZERO;
            y_r       <= Y_ZERO;
            drain_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_r       <= bus.cfg_w;
                        h_r       <= bus.cfg_h;
                        pad_r     <= bus.cfg_pad;
                        s2_r      <= bus.cfg_stride2;
                        bias_en_r <= bus.cfg_bias_en;
                        x_r       <= bus.cfg_pad ? X_ZERO : X_ONE;
                        y_r       <= bus.cfg_pad ? Y_ZERO : Y_ONE;
                        if ((bus.cfg_w < {{(AW_W-1){1'b0}}, 2'd3}) ||
                            (bus.cfg_h < {{(AW_H-1){1'b0}}, 2'd3})) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_SCAN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (!bus.pause) begin
                        if (!last_x_s) begin
                            x_r <= x_sum_s[AW_W:0];
                        end else if (!last_y_s) begin
                            x_r <= pad_r ? X_ZERO : X_ONE;
                            y_r <= y_sum_s[AW_H:0];
                        end else begin
                            drain_r <= 3'd0;
                            state_r <= ST_DRAIN;
                        end
                    end else begin
                        state_r <= ST_SCAN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_r == DRAIN_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        drain_r <= drain_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-latency delay line carrying the tap mask and window-valid alongside memory data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                mask_pipe_r[i] <= 9'd0;
            end
            valid_pipe_r <= {RD_LAT{1'b0}};
        end else begin
            mask_pipe_r[0]  <= rd_en_s;
            valid_pipe_r[0] <= issue_s;
            for (int i = 1; i < RD_LAT; i++) begin
                mask_pipe_r[i]  <= mask_pipe_r[i-1];
                valid_pipe_r[i] <= valid_pipe_r[i-1];
            end
        end
    end

    // Lane masking and bias gating against the delayed strobe
    always_comb begin
        mask_d_s = mask_pipe_r[RD_LAT-1];
        en_d_s   = valid_pipe_r[RD_LAT-1];
        fmap_s   = {(DW*9){1'b0}};
        for (int j = 0; j < 9; j++) begin
            if (en_d_s && mask_d_s[j]) begin
                fmap_s[DW*j +: DW] = bus.fmaps[DW*j +: DW];
            end else begin
                fmap_s[DW*j +: DW] = {DW{1'b0}};
            end
        end
        if (en_d_s && bias_en_r) begin
            biasp_s = bus.biases;
        end else begin
            biasp_s = {BW{1'b0}};
        end
    end

    assign bus.rd_en     = rd_en_s;
    assign bus.readi_w   = readi_w_s;
    assign bus.readi_h   = readi_h_s;
    assign bus.fmap      = fmap_s;
    assign bus.biasp     = biasp_s;
    assign bus.en_pe_out = en_d_s;
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.done      = (state_r == ST_DONE);
endmodule

// File: tb/tb_control_part_scan.sv
// Drives two scanner builds (read latency 1 and 3) with identical stimulus and checks both
// against a window-list model derived directly from the scan rules.
module tb_control_part_scan;
    localparam int DW = 8, AW_W = 7, AW_H = 3, BW = 128;
    localparam int LAT_A = 1, LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [AW_W:0]     cfg_w = '0;
    logic [AW_H:0]     cfg_h = '0;
    logic              cfg_pad = 1'b0, cfg_stride2 = 1'b0, cfg_bias_en = 1'b0, pause = 1'b0;
    logic [DW*9-1:0]   fmaps = '0;
    logic [BW-1:0]     biases = '0;

    int n_cmp = 0;
    int n_bad = 0;

    control_part_scan_if #(.DW(DW), .AW_W(AW_W), .AW_H(AW_H), .BW(BW)) bus_a ();
    control_part_scan_if #(.DW(DW), .AW_W(AW_W), .AW_H(AW_H), .BW(BW)) bus_b ();

    assign bus_a.start = start;        assign bus_b.start = start;
    assign bus_a.cfg_w = cfg_w;        assign bus_b.cfg_w = cfg_w;
    assign bus_a.cfg_h = cfg_h;        assign bus_b.cfg_h = cfg_h;
    assign bus_a.cfg_pad = cfg_pad;    assign bus_b.cfg_pad = cfg_pad;
    assign bus_a.cfg_stride2 = cfg_stride2; assign bus_b.cfg_stride2 = cfg_stride2;
    assign bus_a.cfg_bias_en = cfg_bias_en; assign bus_b.cfg_bias_en = cfg_bias_en;
    assign bus_a.pause = pause;        assign bus_b.pause = pause;
    assign bus_a.fmaps = fmaps;        assign bus_b.fmaps = fmaps;
    assign bus_a.biases = biases;      assign bus_b.biases = biases;

    control_part_scan #(.DW(DW), .AW_W(AW_W), .AW_H(AW_H), .BW(BW), .RD_LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
    control_part_scan #(.DW(DW), .AW_W(AW_W), .AW_H(AW_H), .BW(BW), .RD_LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.master));

    // ---------------- reference model ----------------
    int win_x[$];
    int win_y[$];

    function automatic void build_windows(int w, int h, bit pad, bit s2);
        int lo, hx, hy, st;
        win_x.delete();
        win_y.delete();
        if (w < 3 || h < 3) return;
        lo = pad ? 0 : 1;
        hx = pad ? w - 1 : w - 2;
        hy = pad ? h - 1 : h - 2;
        st = s2 ? 2 : 1;
        for (int y = lo; y <= hy; y += st)
            for (int x = lo; x <= hx; x += st) begin
                win_x.push_back(x);
                win_y.push_back(y);
            end
    endfunction

    function automatic void window_taps(int x, int y, int w, int h, output logic [8:0] m,
                                        output logic [AW_W*9-1:0] aw, output logic [AW_H*9-1:0] ah);
        int tx, ty;
        m = '0; aw = '0; ah = '0;
        for (int k = 0; k < 9; k++) begin
            tx = x + (k % 3) - 1;
            ty = y + (k / 3) - 1;
            if (tx >= 0 && tx < w && ty >= 0 && ty < h) begin
                m[8-k] = 1'b1;
                aw[AW_W*9-1-AW_W*k -: AW_W] = tx[AW_W-1:0];
                ah[AW_H*9-1-AW_H*k -: AW_H] = ty[AW_H-1:0];
            end
        end
    endfunction

    function automatic logic [DW*9-1:0] mask_lanes(logic [8:0] m, logic [DW*9-1:0] fm);
        logic [DW*9-1:0] e;
        e = '0;
        for (int k = 0; k < 9; k++)
            if (m[8-k]) e[DW*9-1-DW*k -: DW] = fm[DW*9-1-DW*k -: DW];
        return e;
    endfunction

    // ---------------- scan scenario engine ----------------
    // pause_pct < 0 selects a fixed pause window on cycles 4..6.
    task automatic test_scan(input string tag, input int w, input int h, input bit pad, input bit s2,
                             input bit ben, input int pause_pct, input bit ff);
        int n, wi, last_iss, idx, lat;
        int iss[$];
        int cnt[2];
        logic [8:0] m, m2;
        logic [AW_W*9-1:0] aw;
        logic [AW_H*9-1:0] ah;
        logic [98:0]  exp_i, obs_i;
        logic [202:0] exp_o, obs_o;
        logic [202:0] obs_d[2];
        logic [DW*9-1:0] efm;
        logic [BW-1:0] ebi;
        logic e_en, e_done, e_busy;
        build_windows(w, h, pad, s2);
        n = win_x.size();
        wi = 0; last_iss = -100; cnt[0] = 0; cnt[1] = 0;
        @(negedge clk);
        start = 1'b1; pause = 1'b0;
        cfg_w = (AW_W+1)'(w); cfg_h = (AW_H+1)'(h);
        cfg_pad = pad; cfg_stride2 = s2; cfg_bias_en = ben;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            start = (wi < n) ? 1'($urandom_range(1)) : 1'b0;
            cfg_w = (AW_W+1)'($urandom); cfg_h = (AW_H+1)'($urandom);
            cfg_pad = 1'($urandom); cfg_stride2 = 1'($urandom); cfg_bias_en = 1'($urandom);
            if (pause_pct < 0) pause = (wi < n) && (cyc >= 4) && (cyc <= 6);
            else pause = (wi < n) && ($urandom_range(99) < pause_pct);
            fmaps = ff ? {(DW*9){1'b1}} : {$urandom, $urandom, $urandom};
            biases = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (wi < n) begin
                window_taps(win_x[wi], win_y[wi], w, h, m, aw, ah);
                if (!pause) begin
                    iss.push_back(wi);
                    wi++;
                    if (wi == n) last_iss = cyc;
                end else begin
                    iss.push_back(-1);
                    m = '0;
                end
            end else begin
                iss.push_back(-1);
                m = '0; aw = '0; ah = '0;
            end
            exp_i = {m, aw, ah};
            obs_i = {bus_a.rd_en, bus_a.readi_w, bus_a.readi_h};
            n_cmp++;
            if (obs_i !== exp_i) begin
                n_bad++;
                $display("FAIL %s issue_a cyc=%0d got=%h want=%h", tag, cyc, obs_i, exp_i);
            end
            obs_i = {bus_b.rd_en, bus_b.readi_w, bus_b.readi_h};
            n_cmp++;
            if (obs_i !== exp_i) begin
                n_bad++;
                $display("FAIL %s issue_b cyc=%0d got=%h want=%h", tag, cyc, obs_i, exp_i);
            end
            obs_d[0] = {bus_a.en_pe_out, bus_a.done, bus_a.busy, bus_a.biasp, bus_a.fmap};
            obs_d[1] = {bus_b.en_pe_out, bus_b.done, bus_b.busy, bus_b.biasp, bus_b.fmap};
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? LAT_A : LAT_B;
                idx = (cyc >= lat) ? iss[cyc-lat] : -1;
                e_en = (idx >= 0);
                if (e_en) begin
                    window_taps(win_x[idx], win_y[idx], w, h, m2, aw, ah);
                    efm = mask_lanes(m2, fmaps);
                    ebi = ben ? biases : '0;
                end else begin
                    efm = '0; ebi = '0;
                end
                if (n == 0) begin
                    e_done = (cyc == 0);
                    e_busy = (cyc == 0);
                end else begin
                    e_done = (wi == n) && (cyc == last_iss + lat + 1);
                    e_busy = !((wi == n) && (cyc > last_iss + lat + 1));
                end
                exp_o = {e_en, e_done, e_busy, ebi, efm};
                obs_o = obs_d[d];
                if (obs_o[202]) cnt[d]++;
                n_cmp++;
                if (obs_o !== exp_o) begin
                    n_bad++;
                    $display("FAIL %s pe_side_lat%0d cyc=%0d got=%h want=%h", tag, lat, cyc, obs_o, exp_o);
                end
            end
            if ((n == 0 && cyc >= 2) || (wi == n && n > 0 && cyc >= last_iss + LAT_B + 3)) break;
        end
        start = 1'b0; pause = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (cnt[d] !== n || wi !== n) begin
                n_bad++;
                $display("FAIL %s pulse_count dut%0d got=%0d want=%0d issued=%0d", tag, d, cnt[d], n, wi);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; cfg_w = 8'd5; cfg_h = 4'd4; cfg_pad = 1'b1;
            fmaps = {$urandom, $urandom, $urandom}; biases = {4{$urandom}};
            #1;
            n_cmp++;
            if ({bus_a.readi_w, bus_a.readi_h, bus_a.rd_en, bus_a.fmap, bus_a.biasp, bus_a.en_pe_out,
                 bus_a.busy, bus_a.done, bus_b.readi_w, bus_b.readi_h, bus_b.rd_en, bus_b.fmap,
                 bus_b.biasp, bus_b.en_pe_out, bus_b.busy, bus_b.done} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got rd_en=%h/%h busy=%b/%b want all zero",
                         i, bus_a.rd_en, bus_b.rd_en, bus_a.busy, bus_b.busy);
            end
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pad_stride1();
        test_scan("pad_5x4_s1", 5, 4, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    endtask

    task automatic test_valid_conv();
        test_scan("valid_5x4_s1", 5, 4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_stride2();
        test_scan("pad_5x4_s2", 5, 4, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        test_scan("valid_8x7_s2", 8, 7, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_pause_bias();
        test_scan("pause_fixed_nobias", 5, 4, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        test_scan("pause_rand_bias", 6, 5, 1'b1, 1'b0, 1'b1, 35, 1'b0);
    endtask

    task automatic test_small_map();
        test_scan("tiny_w2", 2, 5, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        test_scan("tiny_h1", 9, 1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        test_scan("min_3x3_valid", 3, 3, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        start = 1'b1; cfg_w = 8'd6; cfg_h = 4'd5; cfg_pad = 1'b1; cfg_stride2 = 1'b0;
        cfg_bias_en = 1'b1; pause = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        fmaps = {$urandom, $urandom, $urandom}; biases = {4{$urandom}};
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({bus_a.readi_w, bus_a.readi_h, bus_a.rd_en, bus_a.fmap, bus_a.biasp, bus_a.en_pe_out,
                 bus_a.busy, bus_a.done, bus_b.readi_w, bus_b.readi_h, bus_b.rd_en, bus_b.fmap,
                 bus_b.biasp, bus_b.en_pe_out, bus_b.busy, bus_b.done} !== '0) begin
                n_bad++;
                $display("FAIL mid_scan_reset step=%0d got en=%b/%b done=%b/%b busy=%b/%b want all zero",
                         i, bus_a.en_pe_out, bus_b.en_pe_out, bus_a.done, bus_b.done, bus_a.busy, bus_b.busy);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        test_scan("after_reset", 5, 4, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random_maps();
        for (int i = 0; i < 8; i++)
            test_scan("random", $urandom_range(3, 20), $urandom_range(3, 7), 1'($urandom),
                      1'($urandom), 1'($urandom), 25, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_scan("b2b_first", 4, 3, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        test_scan("b2b_second", 7, 4, 1'b0, 1'b0, 1'b1, 10, 1'b0);
    endtask

    initial begin
        test_reset();
        test_pad_stride1();
        test_valid_conv();
        test_stride2();
        test_pause_bias();
        test_small_map();
        test_reset_mid_scan();
        test_random_maps();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
